// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_mp register bank.
//   WIDTH_DEF / DEPTH_DEF : default data width and entry count
//   clr_state_t           : clear-engine state (idle / sweeping)
// Optional build macro used by regfile_mp: REGFILE_MP_BYPASS_EN.
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_mp_vdffe.sv
// ---------------------------------------------------------------------------
// vDFFE
// Load-enable register without reset; one instance holds one register-file
// entry.
//   clk : rising-edge clock
//   en  : load enable, q takes d on the edge when high
//   d   : next value
//   q   : stored value
// ---------------------------------------------------------------------------
module vDFFE #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flop: holds its value unless loaded.
  always_ff @(posedge clk) begin
    if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
// Dual-read, single-write register file with a sequential clear engine.
// After reset, or on a clear request, the engine zeroes one entry per cycle
// for DEPTH cycles; during that sweep busy is high, reads return 0 and
// writes are discarded (recorded in the sticky wr_drop flag).
//
// Ports:
//   clk                : rising-edge clock
//   reset_n            : synchronous active-low reset
//   data_in            : write data
//   writenum / write   : write address / write enable
//   readnum_a/_b       : combinational read addresses
//   clear              : request to zero all entries
//   data_out_a/_b      : read data (0 while busy)
//   busy               : clear engine active
//   wr_drop            : sticky, a write was discarded while busy
//
// Build option: define REGFILE_MP_BYPASS_EN for same-cycle write-through
// forwarding onto the read ports.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  input  logic             clear,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  output logic             busy,
  output logic             wr_drop
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  clr_state_t       state_q, state_d;
  logic [AW-1:0]    clr_idx_q, clr_idx_d;
  logic             wr_drop_q, wr_drop_d;

  logic [WIDTH-1:0] entry_q [DEPTH];
  logic [DEPTH-1:0] entry_en;
  logic [WIDTH-1:0] entry_d;
  logic             write_ok;

  assign busy    = (state_q == S_CLEAR);
  assign wr_drop = wr_drop_q;

  // A write lands only when idle, not colliding with an accepted clear,
  // and not under reset.
  assign write_ok = write & ~busy & ~clear & reset_n;

  // The sweep drives zeros through the same load path used by writes.
  assign entry_d = busy ? {WIDTH{1'b0}} : data_in;

  // Clear-engine state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= {AW{1'b0}};
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Clear-engine next state: sweep counter, sweep start, drop flag.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    wr_drop_d = wr_drop_q;
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          state_d   = S_CLEAR;
          clr_idx_d = {AW{1'b0}};
          wr_drop_d = 1'b0;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_CLEAR: begin
        // clear is ignored here; the running sweep is never restarted.
        if (write) begin
          wr_drop_d = 1'b1;
        end else begin
          wr_drop_d = wr_drop_q;
        end
        if (clr_idx_q == LAST_IDX) begin
          state_d   = S_IDLE;
          clr_idx_d = {AW{1'b0}};
        end else begin
          state_d   = S_CLEAR;
          clr_idx_d = clr_idx_q + {{(AW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = S_CLEAR;
        clr_idx_d = {AW{1'b0}};
        wr_drop_d = 1'b0;
      end
    endcase
  end

  // Per-entry load enable: write decode when idle, sweep pointer when busy.
  always_comb begin
    entry_en = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (busy) begin
        entry_en[i] = (clr_idx_q == AW'(i));
      end else begin
        entry_en[i] = write_ok & (writenum == AW'(i));
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      vDFFE #(.WIDTH(WIDTH)) u_entry (
        .clk (clk),
        .en  (entry_en[gi]),
        .d   (entry_d),
        .q   (entry_q[gi])
      );
    end
  endgenerate

  // Read ports: busy forcing overrides everything, bypass (if built) next.
  always_comb begin
    data_out_a = {WIDTH{1'b0}};
    data_out_b = {WIDTH{1'b0}};
    if (busy) begin
      data_out_a = {WIDTH{1'b0}};
      data_out_b = {WIDTH{1'b0}};
    end else begin
`ifdef REGFILE_MP_BYPASS_EN
      if (write && (readnum_a == writenum)) begin
        data_out_a = data_in;
      end else begin
        data_out_a = entry_q[readnum_a];
      end
      if (write && (readnum_b == writenum)) begin
        data_out_b = data_in;
      end else begin
        data_out_b = entry_q[readnum_b];
      end
`else
      data_out_a = entry_q[readnum_a];
      data_out_b = entry_q[readnum_b];
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
// Self-checking bench for regfile_mp (WIDTH=16, DEPTH=8). A behavioural
// model tracks the contents, the remaining sweep length and the drop flag;
// every cycle's outputs are compared against it, plus a table of directed
// vectors and hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    writenum;
  logic             write;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic             clear;
  logic [WIDTH-1:0] data_out_a;
  logic [WIDTH-1:0] data_out_b;
  logic             busy;
  logic             wr_drop;

  int n_tests;
  int n_fail;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_left;
  logic             m_drop;

  regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .writenum   (writenum),
    .write      (write),
    .readnum_a  (readnum_a),
    .readnum_b  (readnum_b),
    .clear      (clear),
    .data_out_a (data_out_a),
    .data_out_b (data_out_b),
    .busy       (busy),
    .wr_drop    (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] rn);
    logic [WIDTH-1:0] v;
    if (m_left > 0) begin
      v = '0;
    end else begin
      v = m_mem[rn];
`ifdef REGFILE_MP_BYPASS_EN
      if (write && rn == writenum) v = data_in;
`endif
    end
    return v;
  endfunction

  // Apply one cycle: drive inputs, compare against the model, clock, update.
  task automatic step(input logic rn, input logic wr, input logic [AW-1:0] wn,
                      input logic [WIDTH-1:0] din, input logic clr,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input bit chk);
    reset_n = rn; write = wr; writenum = wn; data_in = din; clear = clr;
    readnum_a = ra; readnum_b = rb;
    #3;
    if (chk) begin
      check("busy",    {15'd0, busy},    {15'd0, (m_left > 0)});
      check("wr_drop", {15'd0, wr_drop}, {15'd0, m_drop});
      check("out_a",   data_out_a, model_read(ra));
      check("out_b",   data_out_b, model_read(rb));
    end
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = DEPTH;
      m_drop = 1'b0;
    end else if (m_left > 0) begin
      if (wr) m_drop = 1'b1;
      m_left--;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = DEPTH;
      m_drop = 1'b0;
    end else if (wr) begin
      m_mem[wn] = din;
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, ra, rb, 1'b1);
  endtask

  // Run idle cycles until busy drops; returns the number of busy cycles seen.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (!busy) break;
      cnt++;
      idle(3'd0, 3'd1);
    end
    if (busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: busy still %b after 40 cycles, expected 0", busy);
    end
  endtask

  typedef struct {
    logic             wr;
    logic [AW-1:0]    wn;
    logic [WIDTH-1:0] din;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
  } vec_t;

  vec_t vecs [6];
  int   cnt;
  logic [WIDTH-1:0] exp6;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_left  = DEPTH;
    m_drop  = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    vecs[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd5, 3'd6, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd4, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'hBEEF, 16'h1234};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF};
    vecs[4] = '{1'b1, 3'd3, 16'h0001, 3'd5, 3'd7, 16'h1234, 16'h0000};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'h0001, 16'h0001};

    // 1. Reset: one low edge, then exactly DEPTH busy cycles, all zero.
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b0);
    check("reset_busy", {15'd0, busy}, 16'h0001);
    wait_idle(cnt);
    check("reset_busy_len", 16'(cnt), 16'd8);
    for (int i = 0; i < DEPTH; i++) begin
      idle(AW'(i), AW'(DEPTH - 1 - i));
      check("reset_zero", data_out_a, 16'h0000);
    end

    // 2. Directed write/read vectors.
    foreach (vecs[i]) begin
      reset_n = 1'b1; write = vecs[i].wr; writenum = vecs[i].wn; data_in = vecs[i].din;
      clear = 1'b0; readnum_a = vecs[i].ra; readnum_b = vecs[i].rb;
      #2;
      check("vec_a", data_out_a, vecs[i].exp_a);
      check("vec_b", data_out_b, vecs[i].exp_b);
      #1;
      step(1'b1, vecs[i].wr, vecs[i].wn, vecs[i].din, 1'b0, vecs[i].ra, vecs[i].rb, 1'b1);
    end

    // 3. Write during clear: dropped, flag sticks, entry 2 ends zero.
    step(1'b1, 1'b1, 3'd2, 16'h7777, 1'b0, 3'd2, 3'd2, 1'b1);
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 1'b1);
    idle(3'd2, 3'd2);
    idle(3'd2, 3'd2);
    step(1'b1, 1'b1, 3'd2, 16'hAAAA, 1'b0, 3'd2, 3'd2, 1'b1);
    wait_idle(cnt);
    check("drop_len", 16'(cnt), 16'd5);
    idle(3'd2, 3'd3);
    check("drop_sticky", {15'd0, wr_drop}, 16'h0001);
    check("drop_entry2", data_out_a, 16'h0000);

    // 4. Reset in the 4th busy cycle restarts the full sweep, clears flag.
    step(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd0, 3'd0, 1'b1);
    idle(3'd0, 3'd0);
    step(1'b1, 1'b1, 3'd1, 16'h1111, 1'b0, 3'd0, 3'd0, 1'b1);
    idle(3'd0, 3'd0);
    step(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd0, 1'b1);
    check("rst_mid_drop", {15'd0, wr_drop}, 16'h0000);
    wait_idle(cnt);
    check("rst_mid_len", 16'(cnt), 16'd8);

    // 5. Write and clear together in IDLE: clear wins, flag stays clear.
    step(1'b1, 1'b1, 3'd7, 16'h1357, 1'b0, 3'd7, 3'd7, 1'b1);
    step(1'b1, 1'b1, 3'd7, 16'h5555, 1'b1, 3'd6, 3'd6, 1'b1);
    wait_idle(cnt);
    check("coll_len", 16'(cnt), 16'd8);
    idle(3'd7, 3'd7);
    check("coll_entry7", data_out_a, 16'h0000);
    check("coll_drop", {15'd0, wr_drop}, 16'h0000);

    // 6. Same-cycle read of the entry being written.
`ifdef REGFILE_MP_BYPASS_EN
    exp6 = 16'hC0DE;
`else
    exp6 = 16'h0000;
`endif
    reset_n = 1'b1; write = 1'b1; writenum = 3'd6; data_in = 16'hC0DE;
    clear = 1'b0; readnum_a = 3'd6; readnum_b = 3'd0;
    #2;
    check("bypass_a", data_out_a, exp6);
    #1;
    step(1'b1, 1'b1, 3'd6, 16'hC0DE, 1'b0, 3'd6, 3'd0, 1'b1);
    idle(3'd6, 3'd6);
    check("after_write6", data_out_b, 16'hC0DE);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 59) != 0),
           $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, DEPTH - 1)),
           16'($urandom),
           ($urandom_range(0, 19) == 0),
           AW'($urandom_range(0, DEPTH - 1)),
           AW'($urandom_range(0, DEPTH - 1)),
           1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
